// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with sub-word merge and load extension
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [1:0]  req_lane;
  logic [31:0] req_wdata;
  logic        mem_we_q;
  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Ready only while idle; IDLE encodes as zero so reset leaves the unit ready.
  assign o_req_ready = (state == IDLE);

  // A write strobe must never escape while reset is being applied.
  assign o_mem_we = mem_we_q & ~i_rst;

  // Classify the incoming request as misaligned or illegal.
  always_comb begin
    req_err = 1'b0;
    if (i_req_we) begin
      case (i_req_funct3)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = i_req_addr[0];
        3'b010:  req_err = (i_req_addr[1:0] != 2'b00);
        default: req_err = 1'b1;
      endcase
    end else begin
      case (i_req_funct3)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = i_req_addr[0];
        3'b010:         req_err = (i_req_addr[1:0] != 2'b00);
        default:        req_err = 1'b1;
      endcase
    end
  end

  // Pick the addressed lane from the read word and extend it to 32 bits.
  always_comb begin
    lane_byte = 8'd0;
    case (req_lane)
      2'd0: lane_byte = i_mem_rdata[7:0];
      2'd1: lane_byte = i_mem_rdata[15:8];
      2'd2: lane_byte = i_mem_rdata[23:16];
      2'd3: lane_byte = i_mem_rdata[31:24];
      default: lane_byte = 8'd0;
    endcase
    lane_half = req_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (req_funct3)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'd0, lane_byte};
      3'b101:  load_data = {16'd0, lane_half};
      default: load_data = i_mem_rdata;
    endcase
  end

  // Read-modify-write: drop the store byte/halfword into its lane of the read word.
  always_comb begin
    merged = i_mem_rdata;
    if (req_funct3[0]) begin
      if (req_lane[1]) merged[31:16] = req_wdata[15:0];
      else             merged[15:0]  = req_wdata[15:0];
    end else begin
      case (req_lane)
        2'd0: merged[7:0]   = req_wdata[7:0];
        2'd1: merged[15:8]  = req_wdata[7:0];
        2'd2: merged[23:16] = req_wdata[7:0];
        2'd3: merged[31:24] = req_wdata[7:0];
        default: merged = i_mem_rdata;
      endcase
    end
  end

  // Request sequencer with registered memory and response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      req_we       <= 1'b0;
      req_funct3   <= 3'd0;
      req_lane     <= 2'd0;
      req_wdata    <= 32'd0;
      mem_we_q     <= 1'b0;
      o_mem_addr   <= 32'd0;
      o_mem_wdata  <= 32'd0;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= 32'd0;
      o_resp_err   <= 1'b0;
    end else begin
      o_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            req_we     <= i_req_we;
            req_funct3 <= i_req_funct3;
            req_lane   <= i_req_addr[1:0];
            req_wdata  <= i_req_wdata;
            if (req_err) begin
              state        <= RESP;
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b1;
              o_resp_rdata <= 32'd0;
            end else begin
              state      <= ACCESS;
              o_mem_addr <= {i_req_addr[31:2], 2'b00};
              if (i_req_we && i_req_funct3 == 3'b010) begin
                mem_we_q    <= 1'b1;
                o_mem_wdata <= i_req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (!req_we) begin
            state        <= RESP;
            o_resp_valid <= 1'b1;
            o_resp_err   <= 1'b0;
            o_resp_rdata <= load_data;
            o_mem_addr   <= 32'd0;
          end else if (req_funct3 == 3'b010) begin
            state        <= RESP;
            o_resp_valid <= 1'b1;
            o_resp_err   <= 1'b0;
            o_resp_rdata <= 32'd0;
            mem_we_q     <= 1'b0;
            o_mem_wdata  <= 32'd0;
            o_mem_addr   <= 32'd0;
          end else begin
            state       <= WRITE;
            mem_we_q    <= 1'b1;
            o_mem_wdata <= merged;
          end
        end
        WRITE: begin
          state        <= RESP;
          o_resp_valid <= 1'b1;
          o_resp_err   <= 1'b0;
          o_resp_rdata <= 32'd0;
          mem_we_q     <= 1'b0;
          o_mem_wdata  <= 32'd0;
          o_mem_addr   <= 32'd0;
        end
        RESP: begin
          state      <= IDLE;
          o_resp_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
